// File: rtl/memreq_sequencer_pkg.sv
// memreq_pkg: shared widths and the writeback FIFO entry type
package memreq_pkg;
  localparam int LINE_W = 256;
  localparam int BE_W = 32;
  localparam int ADDR_W = 32;
  localparam int LINE_OFS = 5;
  localparam int LINE_IDX_W = ADDR_W - LINE_OFS;
  typedef struct packed {
    logic [LINE_IDX_W-1:0] line;
    logic [BE_W-1:0]       be;
    logic [LINE_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/memreq_sequencer_if.sv
// memreq_sequencer_if: fill/writeback request ports and main-memory bus
interface memreq_sequencer_if import memreq_pkg::*; #(parameter int ID_W = 4, parameter int WB_DEPTH = 4);
  logic                      fill_req_valid, fill_req_ready;
  logic [ADDR_W-1:0]         fill_req_addr;
  logic [ID_W-1:0]           fill_req_id;
  logic                      fill_rsp_valid;
  logic [ID_W-1:0]           fill_rsp_id;
  logic [LINE_W-1:0]         fill_rsp_data;
  logic                      wb_req_valid, wb_req_ready;
  logic [ADDR_W-1:0]         wb_req_addr;
  logic [BE_W-1:0]           wb_req_be;
  logic [LINE_W-1:0]         wb_req_data;
  logic [ADDR_W-1:0]         mem_a;
  logic                      mem_read, mem_write;
  logic [BE_W-1:0]           mem_be;
  logic [LINE_W-1:0]         mem_wd, mem_rd;
  logic                      mem_valid;
  logic [$clog2(WB_DEPTH):0] wb_count;
  logic                      idle, protocol_err;
  modport master (
    output fill_req_valid, fill_req_addr, fill_req_id, wb_req_valid, wb_req_addr, wb_req_be, wb_req_data,
           mem_rd, mem_valid,
    input  fill_req_ready, fill_rsp_valid, fill_rsp_id, fill_rsp_data, wb_req_ready, mem_a, mem_read,
           mem_write, mem_be, mem_wd, wb_count, idle, protocol_err
  );
  modport slave (
    input  fill_req_valid, fill_req_addr, fill_req_id, wb_req_valid, wb_req_addr, wb_req_be, wb_req_data,
           mem_rd, mem_valid,
    output fill_req_ready, fill_rsp_valid, fill_rsp_id, fill_rsp_data, wb_req_ready, mem_a, mem_read,
           mem_write, mem_be, mem_wd, wb_count, idle, protocol_err
  );
endinterface

// File: rtl/memreq_sequencer_wb_fifo.sv
// wb_fifo: writeback FIFO with a line-match lookup across all valid entries
module wb_fifo import memreq_pkg::*; #(parameter int DEPTH = 4) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  wb_entry_t               din,
  input  logic [LINE_IDX_W-1:0]   cmp_line,
  output wb_entry_t               head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    hit
);
  localparam int PW = $clog2(DEPTH);
  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld, match;
  logic [PW-1:0]    wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      vld <= '0;
      count <= '0;
    end else begin
      if (push) begin
        vld[wp] <= 1'b1;
        wp <= wp + 1'b1;
      end
      if (pop) begin
        vld[rp] <= 1'b0;
        rp <= rp + 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = vld[i] && mem[i].line == cmp_line;
  end
  assign hit = |match;
  assign head = mem[rp];
endmodule

// File: rtl/memreq_sequencer.sv
// memreq_sequencer: schedules fills and buffered writebacks onto main memory,
// one issue per cycle, keeping fills behind any pending write to the same line.
module memreq_sequencer import memreq_pkg::*; #(parameter int WB_DEPTH = 4, parameter int ID_W = 4) (
  input logic               clk,
  input logic               reset,
  memreq_sequencer_if.slave bus
);
  localparam int CW = $clog2(WB_DEPTH) + 1;
  wb_entry_t             din, head;
  logic [LINE_IDX_W-1:0] fill_line, wr_line;
  logic                  hit, full, hazard, do_rd, do_wr, v1, v2;
  logic [ID_W-1:0]       id1, id2;
  assign fill_line = bus.fill_req_addr[ADDR_W-1:LINE_OFS];
  assign din = '{line: bus.wb_req_addr[ADDR_W-1:LINE_OFS], be: bus.wb_req_be, data: bus.wb_req_data};
  wb_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(bus.wb_req_valid && bus.wb_req_ready), .pop(do_wr), .din(din),
    .cmp_line(fill_line), .head(head), .count(bus.wb_count), .hit(hit)
  );
  // a line in its data phase is not yet in memory, so it still blocks fills
  always_comb begin
    full = bus.wb_count == CW'(WB_DEPTH);
    hazard = hit || (bus.mem_write && wr_line == fill_line);
    do_rd = !full && bus.fill_req_valid && !hazard;
    do_wr = !do_rd && bus.wb_count != '0;
  end
  assign bus.fill_req_ready = do_rd;
  assign bus.mem_read = do_rd;
  assign bus.mem_a = do_rd ? ADDR_W'(fill_line) : do_wr ? ADDR_W'(head.line) : '0;
  assign bus.wb_req_ready = !full;
  assign bus.fill_rsp_valid = v2;
  assign bus.fill_rsp_id = id2;
  assign bus.fill_rsp_data = bus.mem_rd;
  assign bus.idle = bus.wb_count == '0 && !v1 && !v2 && !bus.mem_write;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      id1 <= '0;
      id2 <= '0;
      wr_line <= '0;
      bus.mem_write <= 1'b0;
      bus.mem_be <= '0;
      bus.mem_wd <= '0;
      bus.protocol_err <= 1'b0;
    end else begin
      v1 <= do_rd;
      id1 <= bus.fill_req_id;
      v2 <= v1;
      id2 <= id1;
      wr_line <= head.line;
      bus.mem_write <= do_wr;
      bus.mem_be <= do_wr ? head.be : '0;
      bus.mem_wd <= do_wr ? head.data : '0;
      bus.protocol_err <= bus.protocol_err | (v2 != bus.mem_valid);
    end
endmodule
